// File: rtl/i2c_reg_bank.sv
// i2c_reg_bank: register bank behind the I2C slave byte engine.
// Each I2C data byte is one access at the internal pointer. The pointer can be
// loaded from the register-address byte. It can also advance after every access.
// Entries can be made read-only, and reset contents come from a parameter.
//
// Optional feature: define REG_BANK_COR_EN to add parameter COR_MASK.
// A read of entry n with COR_MASK[n]=1 returns the value and then clears the entry.
//
// Ports:
//   i_ck       clock, all state on rising edge
//   i_rstn     asynchronous active-low reset
//   i_csn      0: bank selected; 1: inputs ignored, state held, pulses low
//   i_rw       0: write, 1: read (sampled with i_strobe)
//   i_addr_ld  load pointer from i_address
//   i_address  new pointer value
//   i_strobe   one-cycle access request
//   i_data     write data
//   o_data     read data, held until next read
//   o_valid    pulse: o_data updated this cycle
//   o_addr     current pointer value
//   o_wr_err   pulse: write rejected (read-only or unmapped)
module i2c_reg_bank #(
    parameter int unsigned         DW       = 8,
    parameter int unsigned         AW       = 4,
    parameter int unsigned         DEPTH    = 16,
    parameter logic [DEPTH-1:0]    RO_MASK  = '0,
    parameter logic [DW*DEPTH-1:0] INIT     = '0,
    parameter bit                  AUTO_INC = 1'b1
`ifdef REG_BANK_COR_EN
    ,
    parameter logic [DEPTH-1:0]    COR_MASK = '0
`endif
) (
    input  logic          i_ck,
    input  logic          i_rstn,
    input  logic          i_csn,
    input  logic          i_rw,
    input  logic          i_addr_ld,
    input  logic [AW-1:0] i_address,
    input  logic          i_strobe,
    input  logic [DW-1:0] i_data,
    output logic [DW-1:0] o_data,
    output logic          o_valid,
    output logic [AW-1:0] o_addr,
    output logic          o_wr_err
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW-1:0] ptr_q, ptr_d;
    logic [DW-1:0] data_q, data_d;
    logic          valid_q, valid_d;
    logic          wr_err_q, wr_err_d;

    logic [AW-1:0] acc_addr;
    logic [31:0]   acc_ext;
    logic          mapped;

    // A load in the same cycle as a strobe redirects that access.
    always_comb begin
        acc_addr = i_addr_ld ? i_address : ptr_q;
        acc_ext  = 32'(acc_addr);
        mapped   = acc_ext < DEPTH;
    end

    always_comb begin
        mem_d    = mem_q;
        ptr_d    = ptr_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        wr_err_d = 1'b0;
        if (!i_csn) begin
            if (i_strobe) begin
                if (i_rw) begin
                    valid_d = 1'b1;
                    data_d  = mapped ? mem_q[acc_addr] : '0;
`ifdef REG_BANK_COR_EN
                    // Clear-on-read bypasses read-only protection.
                    if (mapped && COR_MASK[acc_addr]) begin
                        mem_d[acc_addr] = '0;
                    end
`endif
                end else if (mapped && !RO_MASK[acc_addr]) begin
                    mem_d[acc_addr] = i_data;
                end else begin
                    wr_err_d = 1'b1;
                end
                // An unmapped address also wraps the pointer to 0.
                if (AUTO_INC) begin
                    ptr_d = (acc_ext >= DEPTH - 1) ? '0 : acc_addr + AW'(1);
                end else begin
                    ptr_d = acc_addr;
                end
            end else if (i_addr_ld) begin
                ptr_d = i_address;
            end
        end
    end

    always_ff @(posedge i_ck or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int unsigned n = 0; n < DEPTH; n++) begin
                mem_q[n] <= INIT[n*DW +: DW];
            end
            ptr_q    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            ptr_q    <= ptr_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            wr_err_q <= wr_err_d;
        end
    end

    assign o_data   = data_q;
    assign o_valid  = valid_q;
    assign o_addr   = ptr_q;
    assign o_wr_err = wr_err_q;

endmodule
